custom_req_issuer: RTL and testbench
====================================

Name: custom_req_issuer

Overview:
Initiator side of the custom-instruction request/response interface. It accepts operand beats from the vector sequencer and issues them to the custom-instruction unit as registered one-cycle requests. It matches each in-order response against an expected-tag FIFO and buffers results for a backpressured writeback port. Issue is credit-limited because the custom unit's response path has no backpressure, so every issued request must already own a buffer slot.

Parameters:
DATA_W, 64, operand/result width
ADDR_W, 32, destination address width
BE_W, 8, byte-enable width
DEPTH, 4, max beats owned (issued, in flight, or buffered); power of two, >=2

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low (asserted when 0)
in_vld  in  1  sequencer beat valid
in_rdy  out  1  beat accepted when in_vld && in_rdy at clk edge
in_op1  in  DATA_W  operand 1
in_op2  in  DATA_W  operand 2
in_addr  in  ADDR_W  destination address
in_be  in  BE_W  byte enables
req_vld  out  1  request valid to custom unit (one cycle per beat)
req_rdy  in  1  custom unit ready
c_in1  out  DATA_W  operand 1 to unit
c_in2  out  DATA_W  operand 2 to unit
req_addr  out  ADDR_W  request address
req_be  out  BE_W  request byte enables
rsp_vld  in  1  response valid (no backpressure)
rsp_res  in  DATA_W  result
rsp_addr  in  ADDR_W  response address
rsp_be  in  BE_W  response byte enables
wb_vld  out  1  writeback valid
wb_rdy  in  1  writeback ready
wb_data  out  DATA_W  result to writeback
wb_addr  out  ADDR_W  writeback address
wb_be  out  BE_W  writeback byte enables
occ  out  $clog2(DEPTH)+1  owned-beat count
rsp_err  out  1  sticky protocol error

Behaviour:
- Reset values: in_rdy=0, req_vld=0, c_in1/c_in2/req_addr/req_be=0, wb_vld=0, wb_data/wb_addr/wb_be=0, occ=0, rsp_err=0. Both FIFOs are emptied.
- in_rdy = req_rdy && (occ < DEPTH), driven from registered state and req_rdy only. No combinational path from wb_rdy.
- occ increments on an in handshake and decrements on a wb handshake. Simultaneous increment and decrement leaves it unchanged. When occ==DEPTH, in_rdy stays 0 even if wb_rdy=1 in the same cycle.
- Issue on in handshake at edge E0: req_vld=1, c_in1/c_in2/req_addr/req_be are loaded, and {in_addr,in_be} is pushed into the tag FIFO. If no handshake occurs, req_vld=0 and the data registers hold their value.
- Back-to-back beats give one req_vld per cycle.
- The unit registers the request at E1, so rsp_vld is seen in the cycle after E1.
- On rsp_vld with the tag FIFO non-empty:
  - pop the tag;
  - push {rsp_res,rsp_addr,rsp_be} into the response buffer;
  - if rsp_addr or rsp_be differs from the tag, set rsp_err, but still buffer the response.
- On rsp_vld with the tag FIFO empty: drop the response, set rsp_err, leave occ unchanged.
- Response buffer write happens at E2; wb_vld is asserted in the cycle after E2. Minimum latency from in handshake to wb_vld is 3 cycles.
- The response buffer is a first-word-fall-through FIFO: wb_* shows the head entry, and a wb handshake pops it. Push and pop in the same cycle are allowed at any fill level. Overflow cannot occur by construction; the bench asserts this.
- Ordering: writeback order equals acceptance order.
- req_rdy low: in_rdy=0 and no new issue. Beats already in flight still complete.
- rsp_err is cleared only by reset.
- Reset mid-operation clears all state immediately. Any rsp_vld arriving after reset release hits an empty tag FIFO, so it is dropped and flags rsp_err.
- Pointer wrap: FIFO pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. Full/empty are derived from a separate count.

Decomposition:
- Package custom_if_pkg:
  - constants DATA_W, ADDR_W, BE_W;
  - typedef struct custom_req_t {op1, op2, addr, be};
  - typedef struct custom_rsp_t {res, addr, be};
  - typedef struct custom_tag_t {addr, be}.
- One sub-module, sync_fifo: parameterised WIDTH/DEPTH, first-word-fall-through, count output, same clk/rst. Instantiated twice: tag FIFO and response buffer.

Test Plan:
- Single beat op1=10, op2=3, addr=0x100, be=0xFF, wb_rdy=1 -> wb_vld exactly 3 cycles after the handshake with wb_data=7, wb_addr=0x100, wb_be=0xFF; rsp_err=0.
- op1=3, op2=10 -> wb_data=7; op1=0, op2=0xFFFF_FFFF_FFFF_FFFF -> wb_data=0xFFFF_FFFF_FFFF_FFFF.
- 6 back-to-back beats (addr 0..5) with wb_rdy=0 -> exactly 4 accepted, occ=4, in_rdy=0. Raise wb_rdy -> results drain in order 0..3. Beats 4..5 accept only from the cycle after occ drops; in_rdy is not raised in the same cycle as the wb handshake at occ==4.
- req_rdy=0 for 5 cycles with in_vld=1 -> no req_vld and in_rdy=0. After req_rdy=1, issue resumes with no lost or duplicated beat.
- Inject rsp_vld with an empty tag FIFO -> rsp_err=1 stays set and wb_vld stays 0. Inject a response with mismatched rsp_addr -> rsp_err=1 and the beat is still written back.
- Assert rst (0) with 2 beats in flight -> all outputs go to reset values asynchronously. The late rsp_vld after release is dropped and rsp_err=1.

Source files
------------

// File: rtl/custom_req_issuer_pkg.sv
// Shared widths and bus payload types for the custom-instruction request/response path.
package custom_if_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BE_W   = 8;

  typedef struct packed {
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
  } custom_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
  } custom_rsp_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
  } custom_tag_t;

endpackage

// File: rtl/custom_req_issuer_if.sv
// Bundle of sequencer, custom-unit and writeback signals around the request issuer.
interface custom_req_issuer_if #(
  parameter int unsigned DEPTH = 4
) ();
  import custom_if_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              in_vld;
  logic              in_rdy;
  logic [DATA_W-1:0] in_op1;
  logic [DATA_W-1:0] in_op2;
  logic [ADDR_W-1:0] in_addr;
  logic [BE_W-1:0]   in_be;

  logic              req_vld;
  logic              req_rdy;
  logic [DATA_W-1:0] c_in1;
  logic [DATA_W-1:0] c_in2;
  logic [ADDR_W-1:0] req_addr;
  logic [BE_W-1:0]   req_be;

  logic              rsp_vld;
  logic [DATA_W-1:0] rsp_res;
  logic [ADDR_W-1:0] rsp_addr;
  logic [BE_W-1:0]   rsp_be;

  logic              wb_vld;
  logic              wb_rdy;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] wb_addr;
  logic [BE_W-1:0]   wb_be;

  logic [CNT_W-1:0]  occ;
  logic              rsp_err;

  modport master (
    input  in_vld, in_op1, in_op2, in_addr, in_be,
    input  req_rdy, rsp_vld, rsp_res, rsp_addr, rsp_be, wb_rdy,
    output in_rdy, req_vld, c_in1, c_in2, req_addr, req_be,
    output wb_vld, wb_data, wb_addr, wb_be, occ, rsp_err
  );

  modport slave (
    output in_vld, in_op1, in_op2, in_addr, in_be,
    output req_rdy, rsp_vld, rsp_res, rsp_addr, rsp_be, wb_rdy,
    input  in_rdy, req_vld, c_in1, c_in2, req_addr, req_be,
    input  wb_vld, wb_data, wb_addr, wb_be, occ, rsp_err
  );

endinterface

// File: rtl/custom_req_issuer_sync_fifo.sv
// First-word-fall-through FIFO; full/empty come from a separate count so pointers wrap freely.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop_i && (cnt_q != '0);
    do_push  = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
      end
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/custom_req_issuer.sv
// Credit-limited issuer: every accepted beat owns a response-buffer slot until written back,
// because the custom unit's response path cannot be stalled.
module custom_req_issuer
  import custom_if_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst,
  custom_req_issuer_if.master bus
);

  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int unsigned TAG_W = $bits(custom_tag_t);
  localparam int unsigned RSP_W = $bits(custom_rsp_t);

  logic        run_q;
  logic [CW-1:0] occ_q, occ_d;
  logic        req_vld_q, req_vld_d;
  custom_req_t req_q, req_d;
  logic        err_q, err_d;

  logic        in_rdy_c, in_hs, wb_vld_c, wb_hs, tag_pop;
  custom_tag_t tag_in, tag_head;
  custom_rsp_t rsp_in, rsp_head;
  logic [TAG_W-1:0] tag_dout;
  logic [RSP_W-1:0] rsp_dout;
  logic [CW-1:0]    tag_cnt, rsp_cnt;

  // run_q keeps in_rdy low during reset and the first cycle after release.
  always_comb begin
    in_rdy_c  = run_q && bus.req_rdy && (occ_q < CW'(DEPTH));
    in_hs     = bus.in_vld && in_rdy_c;
    wb_vld_c  = (rsp_cnt != '0);
    wb_hs     = wb_vld_c && bus.wb_rdy;
    tag_pop   = bus.rsp_vld && (tag_cnt != '0);
    tag_head  = custom_tag_t'(tag_dout);
    rsp_head  = custom_rsp_t'(rsp_dout);
    tag_in    = '{addr: bus.in_addr, be: bus.in_be};
    rsp_in    = '{res: bus.rsp_res, addr: bus.rsp_addr, be: bus.rsp_be};

    req_vld_d = in_hs;
    req_d     = req_q;
    if (in_hs) begin
      req_d = '{op1: bus.in_op1, op2: bus.in_op2, addr: bus.in_addr, be: bus.in_be};
    end

    occ_d = occ_q + CW'(in_hs) - CW'(wb_hs);

    // Orphan responses are dropped; mismatched ones are still buffered but flagged.
    err_d = err_q;
    if (bus.rsp_vld && (!tag_pop || (tag_head.addr != bus.rsp_addr) ||
                        (tag_head.be != bus.rsp_be))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q     <= 1'b0;
      occ_q     <= '0;
      req_vld_q <= 1'b0;
      req_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      run_q     <= 1'b1;
      occ_q     <= occ_d;
      req_vld_q <= req_vld_d;
      req_q     <= req_d;
      err_q     <= err_d;
    end
  end

  sync_fifo #(.WIDTH(TAG_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (in_hs),
    .din_i   (tag_in),
    .pop_i   (tag_pop),
    .dout_o  (tag_dout),
    .count_o (tag_cnt)
  );

  sync_fifo #(.WIDTH(RSP_W), .DEPTH(DEPTH)) u_rsp_buf (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (tag_pop),
    .din_i   (rsp_in),
    .pop_i   (wb_hs),
    .dout_o  (rsp_dout),
    .count_o (rsp_cnt)
  );

  assign bus.in_rdy   = in_rdy_c;
  assign bus.req_vld  = req_vld_q;
  assign bus.c_in1    = req_q.op1;
  assign bus.c_in2    = req_q.op2;
  assign bus.req_addr = req_q.addr;
  assign bus.req_be   = req_q.be;
  assign bus.wb_vld   = wb_vld_c;
  assign bus.wb_data  = rsp_head.res;
  assign bus.wb_addr  = rsp_head.addr;
  assign bus.wb_be    = rsp_head.be;
  assign bus.occ      = occ_q;
  assign bus.rsp_err  = err_q;

endmodule

// File: tb/tb_custom_req_issuer.sv
// Bench for custom_req_issuer: absolute-difference custom unit model, queue-based scoreboard, directed tests.
module tb_custom_req_issuer;
  import custom_if_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  custom_req_issuer_if #(.DEPTH(DEPTH)) bus ();
  custom_req_issuer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] absdiff(logic [63:0] a, logic [63:0] b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Custom unit: registers a request and answers |op1-op2| in the following cycle.
  logic        pend_v = 1'b0;
  custom_rsp_t pend;
  logic        inj_v = 1'b0;
  custom_rsp_t inj;
  logic        corrupt = 1'b0;

  always @(negedge clk) begin
    if (bus.req_vld) begin
      pend_v = 1'b1;
      pend   = '{res: absdiff(bus.c_in1, bus.c_in2),
                 addr: bus.req_addr ^ (corrupt ? 32'h1 : 32'h0), be: bus.req_be};
    end
  end

  always @(posedge clk) begin
    #2;
    if (inj_v) begin
      bus.rsp_vld = 1'b1; bus.rsp_res = inj.res; bus.rsp_addr = inj.addr; bus.rsp_be = inj.be;
      inj_v = 1'b0;
    end else if (pend_v) begin
      bus.rsp_vld = 1'b1; bus.rsp_res = pend.res; bus.rsp_addr = pend.addr; bus.rsp_be = pend.be;
      pend_v = 1'b0;
    end else begin
      bus.rsp_vld = 1'b0;
    end
  end

  // Scoreboard: expected outputs of the current cycle, advanced from this cycle's inputs.
  int          occ_m = 0;
  bit          live_m = 0;
  bit          rv_m = 0;
  bit          err_m = 0;
  custom_req_t rq_m = '0;
  custom_tag_t tagq[$];
  custom_rsp_t wbq[$];
  custom_rsp_t accq[$];
  int          wb_count = 0;

  always @(negedge clk) begin : cmp
    bit in_rdy_m, hs_in, hs_wb;
    custom_tag_t t;
    custom_rsp_t a;
    if (!rst) begin
      chk("rst_in_rdy", bus.in_rdy, 0);
      chk("rst_req_vld", bus.req_vld, 0);
      chk("rst_wb_vld", bus.wb_vld, 0);
      chk("rst_occ", bus.occ, 0);
      chk("rst_err", bus.rsp_err, 0);
      occ_m = 0; live_m = 0; rv_m = 0; err_m = 0; rq_m = '0;
      tagq.delete(); wbq.delete(); accq.delete();
    end else begin
      in_rdy_m = live_m && bus.req_rdy && (occ_m < DEPTH);
      chk("in_rdy", bus.in_rdy, in_rdy_m);
      chk("req_vld", bus.req_vld, rv_m);
      chk("c_in1", bus.c_in1, rq_m.op1);
      chk("c_in2", bus.c_in2, rq_m.op2);
      chk("req_addr", bus.req_addr, rq_m.addr);
      chk("req_be", bus.req_be, rq_m.be);
      chk("wb_vld", bus.wb_vld, wbq.size() > 0);
      if (wbq.size() > 0) begin
        chk("wb_data", bus.wb_data, wbq[0].res);
        chk("wb_addr", bus.wb_addr, wbq[0].addr);
        chk("wb_be", bus.wb_be, wbq[0].be);
      end
      chk("occ", bus.occ, occ_m);
      chk("rsp_err", bus.rsp_err, err_m);
      chk("rsp_buf_bound", dut.rsp_cnt <= DEPTH, 1);

      hs_in = bus.in_vld && in_rdy_m;
      hs_wb = bus.wb_rdy && (wbq.size() > 0);
      if (hs_wb) begin
        void'(wbq.pop_front());
        if (accq.size() > 0) begin
          a = accq.pop_front();
          chk("wb_order", bus.wb_data, a.res);
        end
        wb_count++;
      end
      if (bus.rsp_vld) begin
        if (tagq.size() > 0) begin
          t = tagq.pop_front();
          if (t.addr != bus.rsp_addr || t.be != bus.rsp_be) err_m = 1;
          wbq.push_back('{res: bus.rsp_res, addr: bus.rsp_addr, be: bus.rsp_be});
        end else begin
          err_m = 1;
        end
      end
      if (hs_in) begin
        tagq.push_back('{addr: bus.in_addr, be: bus.in_be});
        accq.push_back('{res: absdiff(bus.in_op1, bus.in_op2), addr: bus.in_addr, be: bus.in_be});
        rq_m = '{op1: bus.in_op1, op2: bus.in_op2, addr: bus.in_addr, be: bus.in_be};
      end
      rv_m   = hs_in;
      occ_m  = occ_m + int'(hs_in) - int'(hs_wb);
      live_m = 1;
    end
  end

  task automatic set_beat(logic [63:0] a, logic [63:0] b, logic [31:0] ad, logic [7:0] be);
    bus.in_op1 = a; bus.in_op2 = b; bus.in_addr = ad; bus.in_be = be;
  endtask

  // Holds one beat until accepted; entered and left at posedge+1.
  task automatic send(logic [63:0] a, logic [63:0] b, logic [31:0] ad, logic [7:0] be);
    int n = 0;
    bit acc = 0;
    bus.in_vld = 1'b1;
    set_beat(a, b, ad, be);
    while (!acc && n < 100) begin
      @(negedge clk); acc = bus.in_rdy; n++;
      @(posedge clk); #1;
    end
    chk("send_accept", acc, 1);
    bus.in_vld = 1'b0;
  endtask

  task automatic wait_wb(string nm, logic [63:0] d, logic [31:0] ad, logic [7:0] be);
    int k = 0;
    bit got = 0;
    while (!got && k < 12) begin
      @(negedge clk); k++;
      if (bus.wb_vld) begin
        got = 1;
        chk({nm, "_data"}, bus.wb_data, d);
        chk({nm, "_addr"}, bus.wb_addr, ad);
        chk({nm, "_be"}, bus.wb_be, be);
      end
    end
    chk({nm, "_lat"}, k, 3);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int idx, base;
    bus.in_vld = 1'b0; set_beat('0, '0, '0, '0);
    bus.req_rdy = 1'b1; bus.wb_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_rdy", bus.in_rdy, 0);
    chk("reset_wb_data", bus.wb_data, 0);
    chk("reset_c_in1", bus.c_in1, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single beats with hand-computed results.
    send(64'd10, 64'd3, 32'h100, 8'hFF);
    wait_wb("t1", 64'd7, 32'h100, 8'hFF);
    chk("t1_err", bus.rsp_err, 0);
    send(64'd3, 64'd10, 32'h104, 8'h0F);
    wait_wb("t2", 64'd7, 32'h104, 8'h0F);
    send(64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h108, 8'hF0);
    wait_wb("t3", 64'hFFFF_FFFF_FFFF_FFFF, 32'h108, 8'hF0);

    // Six back-to-back beats against a stalled writeback port.
    bus.wb_rdy = 1'b0;
    base = wb_count;
    idx = 0;
    bus.in_vld = 1'b1;
    set_beat(64'd0, 64'd7, 32'd0, 8'hFF);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); if (bus.in_rdy) idx++;
      @(posedge clk); #1;
      set_beat(64'(idx * 3), 64'd7, 32'(idx), 8'hFF);
    end
    chk("t4_accepted", idx, 4);
    chk("t4_occ", bus.occ, 4);
    chk("t4_in_rdy", bus.in_rdy, 0);
    bus.wb_rdy = 1'b1;
    @(negedge clk);
    chk("t4_no_same_cycle_rdy", bus.in_rdy, 0);
    @(posedge clk); #1;
    for (int c = 0; c < 20 && idx < 6; c++) begin
      @(negedge clk); if (bus.in_rdy) idx++;
      @(posedge clk); #1;
      if (idx < 6) set_beat(64'(idx * 3), 64'd7, 32'(idx), 8'hFF);
      else bus.in_vld = 1'b0;
    end
    bus.in_vld = 1'b0;
    chk("t4_all_sent", idx, 6);
    repeat (8) @(posedge clk);
    #1;
    chk("t4_drained", wb_count - base, 6);
    chk("t4_occ_end", bus.occ, 0);

    // Custom unit not ready: nothing issues, then the held beat goes exactly once.
    base = wb_count;
    bus.req_rdy = 1'b0;
    bus.in_vld = 1'b1;
    set_beat(64'd20, 64'd5, 32'h200, 8'h3C);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t5_stall_rdy", bus.in_rdy, 0);
      chk("t5_stall_req", bus.req_vld, 0);
      @(posedge clk); #1;
    end
    bus.req_rdy = 1'b1;
    send(64'd20, 64'd5, 32'h200, 8'h3C);
    send(64'd1, 64'd2, 32'h204, 8'h03);
    send(64'd9, 64'd9, 32'h208, 8'hC0);
    repeat (8) @(posedge clk);
    #1;
    chk("t5_count", wb_count - base, 3);

    // Response carrying the wrong address: flagged but still written back.
    do_reset();
    corrupt = 1'b1;
    send(64'd50, 64'd8, 32'h300, 8'hAA);
    wait_wb("t6", 64'd42, 32'h301, 8'hAA);
    corrupt = 1'b0;
    chk("t6_err", bus.rsp_err, 1);

    // Orphan response with nothing outstanding.
    do_reset();
    chk("t7_err_clear", bus.rsp_err, 0);
    inj = '{res: 64'd5, addr: 32'h400, be: 8'h01};
    inj_v = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t7_no_wb", bus.wb_vld, 0);
      @(posedge clk); #1;
    end
    chk("t7_err", bus.rsp_err, 1);
    chk("t7_occ", bus.occ, 0);

    // Reset with two beats in flight, then the late response arrives.
    do_reset();
    bus.wb_rdy = 1'b0;
    send(64'd7, 64'd2, 32'h500, 8'hFF);
    send(64'd8, 64'd2, 32'h504, 8'hFF);
    #2; rst = 1'b0;
    #1;
    chk("t8_async_req_vld", bus.req_vld, 0);
    chk("t8_async_occ", bus.occ, 0);
    chk("t8_async_in_rdy", bus.in_rdy, 0);
    chk("t8_async_c_in1", bus.c_in1, 0);
    chk("t8_async_wb_vld", bus.wb_vld, 0);
    chk("t8_async_err", bus.rsp_err, 0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    inj = '{res: 64'd6, addr: 32'h504, be: 8'hFF};
    inj_v = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t8_no_wb", bus.wb_vld, 0);
      @(posedge clk); #1;
    end
    chk("t8_err", bus.rsp_err, 1);
    chk("t8_occ", bus.occ, 0);
    bus.wb_rdy = 1'b1;

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
